// File: rtl/denormalize_64.sv
// Iterative logarithmic right shifter: restores a normalized word by shifting it
// right by a leading-zero count, one count bit per cycle, behind valid/ready handshakes.
module denormalize_64 #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CW    = 7
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_VALID,
  output logic             o_READY,
  input  logic [WIDTH-1:0] i_WORD,
  input  logic [CW-1:0]    i_COUNT,
  output logic             o_VALID,
  input  logic             i_READY,
  output logic [WIDTH-1:0] o_WORD,
  output logic             o_ZERO,
  output logic             o_ERR
);

  localparam int unsigned    KW        = $clog2(CW);
  localparam logic [CW-1:0]  MAX_COUNT = CW'(WIDTH);
  localparam logic [KW-1:0]  LAST_STEP = KW'(CW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_nxt;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    step_amt;
  logic [KW-1:0]    k_q;
  logic             err_q;

  // Stage k shifts by 2^k when count bit k is set; the last stage (2^(CW-1) = WIDTH)
  // clears the word entirely, which is how a saturated count yields zero.
  always_comb begin
    step_amt = CW'(1) << k_q;
    data_nxt = data_q;
    if (count_q[k_q]) begin
      data_nxt = data_q >> step_amt;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state   <= IDLE;
      o_READY <= 1'b1;
      o_VALID <= 1'b0;
      o_WORD  <= '0;
      o_ZERO  <= 1'b0;
      o_ERR   <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_VALID) begin
            data_q  <= i_WORD;
            k_q     <= '0;
            o_READY <= 1'b0;
            state   <= SHIFT;
            if (i_COUNT > MAX_COUNT) begin
              count_q <= MAX_COUNT;
              err_q   <= 1'b1;
            end else begin
              count_q <= i_COUNT;
              err_q   <= 1'b0;
            end
          end
        end
        SHIFT: begin
          data_q <= data_nxt;
          if (k_q == LAST_STEP) begin
            k_q     <= '0;
            state   <= DONE;
            o_VALID <= 1'b1;
            o_WORD  <= data_nxt;
            o_ZERO  <= (data_nxt == '0);
            o_ERR   <= err_q;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (i_READY) begin
            state   <= IDLE;
            o_VALID <= 1'b0;
            o_READY <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          o_READY <= 1'b1;
          o_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_denormalize_64.sv
// Self-checking bench for denormalize_64: directed vector table, handshake corner
// sequences and randomized transactions against an arithmetic reference model.
module tb_denormalize_64;

  logic        i_CLK = 1'b0;
  logic        i_RST = 1'b1;
  logic        i_VALID = 1'b0;
  logic        o_READY;
  logic [63:0] i_WORD = '0;
  logic [6:0]  i_COUNT = '0;
  logic        o_VALID;
  logic        i_READY = 1'b0;
  logic [63:0] o_WORD;
  logic        o_ZERO;
  logic        o_ERR;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int last_rise = 0;

  denormalize_64 #(.WIDTH(64), .CW(7)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_VALID(i_VALID), .o_READY(o_READY),
    .i_WORD(i_WORD), .i_COUNT(i_COUNT), .o_VALID(o_VALID), .i_READY(i_READY),
    .o_WORD(o_WORD), .o_ZERO(o_ZERO), .o_ERR(o_ERR)
  );

  always #5 i_CLK = ~i_CLK;
  always @(posedge i_CLK) cycle <= cycle + 1;

  typedef struct {
    logic [63:0] word;
    logic [6:0]  count;
    logic [63:0] exp_word;
    logic        exp_zero;
    logic        exp_err;
  } vec_t;

  function automatic logic [63:0] model(input logic [63:0] w, input int c);
    if (c >= 64) return 64'd0;
    return w >> c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One transaction: bp = cycles of backpressure after o_VALID rises,
  // hold = leave i_VALID asserted after acceptance.
  task automatic txn(input logic [63:0] w, input logic [6:0] c, input logic [63:0] ew,
                     input logic ez, input logic ee, input int bp, input bit hold);
    int t;
    int lat;
    logic [63:0] held;
    t = 0;
    while (!o_READY && t < 20) begin
      @(negedge i_CLK);
      t++;
    end
    if (!o_READY) begin
      chk("ready_timeout", 64'(o_READY), 64'd1);
      return;
    end
    i_VALID = 1'b1;
    i_WORD  = w;
    i_COUNT = c;
    i_READY = (bp == 0);
    @(posedge i_CLK);
    @(negedge i_CLK);
    if (!hold) i_VALID = 1'b0;
    chk("busy_after_accept", 64'(o_READY), 64'd0);
    lat = 0;
    while (!o_VALID && lat < 20) begin
      @(negedge i_CLK);
      lat++;
    end
    last_rise = cycle;
    chk("latency", 64'(lat), 64'd7);
    if (!o_VALID) return;
    chk("word", o_WORD, ew);
    chk("zero", 64'(o_ZERO), 64'(ez));
    chk("err", 64'(o_ERR), 64'(ee));
    held = o_WORD;
    for (int i = 0; i < bp; i++) begin
      @(negedge i_CLK);
      chk("bp_valid", 64'(o_VALID), 64'd1);
      chk("bp_word", o_WORD, held);
      chk("bp_ready", 64'(o_READY), 64'd0);
    end
    i_READY = 1'b1;
    @(negedge i_CLK);
    chk("valid_drop", 64'(o_VALID), 64'd0);
    chk("ready_back", 64'(o_READY), 64'd1);
    i_READY = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int r1, r2;
    logic [63:0] w;
    int c;
    int stale;

    vecs[0] = '{64'hD540_5104_0000_0000, 7'd31,  64'h0000_0001_AA80_A208, 1'b0, 1'b0};
    vecs[1] = '{64'h8000_0000_0000_0001, 7'd0,   64'h8000_0000_0000_0001, 1'b0, 1'b0};
    vecs[2] = '{64'h8000_0000_0000_0000, 7'd63,  64'h0000_0000_0000_0001, 1'b0, 1'b0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd64,  64'h0,                   1'b1, 1'b0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd100, 64'h0,                   1'b1, 1'b1};
    vecs[5] = '{64'h1234_5678_9ABC_DEF0, 7'd127, 64'h0,                   1'b1, 1'b1};

    repeat (3) @(negedge i_CLK);
    i_RST = 1'b0;
    chk("rst_ready", 64'(o_READY), 64'd1);
    chk("rst_valid", 64'(o_VALID), 64'd0);
    chk("rst_word", o_WORD, 64'd0);
    chk("rst_zero", 64'(o_ZERO), 64'd0);
    chk("rst_err", 64'(o_ERR), 64'd0);

    for (int i = 0; i < 6; i++)
      txn(vecs[i].word, vecs[i].count, vecs[i].exp_word, vecs[i].exp_zero, vecs[i].exp_err, 0, 1'b0);

    // Backpressure for 5 cycles, then immediate follow-on acceptance.
    txn(64'hC000_0000_0000_0000, 7'd2, 64'h3000_0000_0000_0000, 1'b0, 1'b0, 5, 1'b0);
    txn(64'h8000_0000_0000_0000, 7'd4, 64'h0800_0000_0000_0000, 1'b0, 1'b0, 0, 1'b0);

    // Back-to-back with i_VALID held high: results spaced 9 cycles apart.
    txn(64'h8000_0000_0000_0000, 7'd1, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 0, 1'b1);
    r1 = last_rise;
    txn(64'h8000_0000_0000_0000, 7'd2, 64'h2000_0000_0000_0000, 1'b0, 1'b0, 0, 1'b1);
    r2 = last_rise;
    chk("b2b_spacing1", 64'(r2 - r1), 64'd9);
    txn(64'h8000_0000_0000_0000, 7'd3, 64'h1000_0000_0000_0000, 1'b0, 1'b0, 0, 1'b1);
    chk("b2b_spacing2", 64'(last_rise - r2), 64'd9);
    i_VALID = 1'b0;

    // Reset at step k = 3 of a transaction; o_WORD is nonzero beforehand.
    txn(64'h8000_0000_0000_0000, 7'd1, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 0, 1'b0);
    i_VALID = 1'b1;
    i_WORD  = 64'hFFFF_0000_FFFF_0000;
    i_COUNT = 7'd5;
    i_READY = 1'b1;
    @(posedge i_CLK);
    @(negedge i_CLK);
    i_VALID = 1'b0;
    repeat (3) @(negedge i_CLK);
    i_RST = 1'b1;
    @(negedge i_CLK);
    i_RST = 1'b0;
    chk("midrst_ready", 64'(o_READY), 64'd1);
    chk("midrst_valid", 64'(o_VALID), 64'd0);
    chk("midrst_word", o_WORD, 64'd0);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge i_CLK);
      if (o_VALID) stale++;
    end
    chk("midrst_no_stale", 64'(stale), 64'd0);
    i_READY = 1'b0;

    for (int i = 0; i < 40; i++) begin
      w = {$urandom, $urandom};
      if (i % 4 == 0) w[63] = 1'b1;
      c = $urandom_range(0, 72);
      if (i == 10) c = 127;
      txn(w, 7'(c), model(w, c), (model(w, c) == 64'd0), (c > 64), $urandom_range(0, 3), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/denormalize_64.md
Name: denormalize_64

Overview:
- Inverse companion to count_leading_zeros_64.
- Takes a normalized 64-bit word and a leading-zero count, and restores the original word by logical right shift: o_WORD = i_WORD >> i_COUNT.
- Iterative log shifter: one shift-amount bit per cycle, fixed 7-cycle latency.
- Valid/ready handshake on both sides; sits downstream of the normalize path in the arithmetic library.

Parameters:
- WIDTH, 64, data width; must be a power of two.
- CW, 7, count width = log2(WIDTH)+1, so a count of WIDTH is representable.

Ports:
- i_CLK  input  1  clock; all state updates on rising edge.
- i_RST  input  1  synchronous, active-high reset.
- i_VALID  input  1  input word/count valid.
- o_READY  output  1  block can accept an input.
- i_WORD  input  WIDTH  normalized word.
- i_COUNT  input  CW  right-shift amount, 0..WIDTH legal.
- o_VALID  output  1  result valid.
- i_READY  input  1  downstream accepts result.
- o_WORD  output  WIDTH  restored word.
- o_ZERO  output  1  o_WORD == 0; valid with o_VALID.
- o_ERR  output  1  i_COUNT > WIDTH on the accepted transaction; valid with o_VALID.

Behaviour:
- Reset values (i_RST high at an edge):
  - state = IDLE; o_READY = 1; o_VALID = 0.
  - o_WORD = 0, o_ZERO = 0, o_ERR = 0; internal step counter = 0.
- Reset mid-operation abandons the transaction; no result is emitted.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - o_READY = 1.
  - On i_VALID at an edge: latch i_WORD into the data register, latch i_COUNT into the count register, set k = 0, go to SHIFT.
  - If i_COUNT > WIDTH: latch i_COUNT as WIDTH and set the err flag.
- SHIFT:
  - o_READY = 0, o_VALID = 0.
  - Each cycle: if count bit k is 1, data <= data >> 2^k, else data unchanged; then k <= k+1.
  - At k = CW-1 (last stage), the update is applied and the FSM goes to DONE.
  - Exactly CW = 7 cycles in SHIFT.
- DONE:
  - o_VALID = 1.
  - o_WORD, o_ZERO and o_ERR are held stable until handshake completes.
  - On i_READY at an edge: go to IDLE; o_VALID drops the next cycle.
  - i_VALID and i_READY may both be high in DONE; the input is not accepted (o_READY = 0). The new input is accepted in IDLE on the following cycle at the earliest.
- Latency:
  - Input accepted at edge N → o_VALID high after edge N+7.
  - With i_READY held high: o_VALID is high for exactly 1 cycle.
  - Throughput is one transaction per 9 cycles.
- Arithmetic:
  - Logical shift with zero fill.
  - Count 0 → o_WORD = i_WORD; count WIDTH → o_WORD = 0.
  - Out-of-range count saturates to WIDTH: o_WORD = 0, o_ZERO = 1, o_ERR = 1.
- Backpressure: i_READY low in DONE holds the state indefinitely; no input is accepted while waiting.
- Input values are not required to be normalized (MSB set); any word is shifted as given.
- o_WORD may change only on entry to DONE or on reset. Intermediate shift values are kept in an internal register, not driven onto o_WORD.

Test Plan:
- Round trip with the CLZ pair:
  - Stimulus: i_WORD = 0xD540_5104_0000_0000, i_COUNT = 31, i_READY = 1.
  - Response: o_VALID 7 cycles after accept; o_WORD = 0x0000_0001_AA80_A208; o_ZERO = 0, o_ERR = 0.
- Boundary counts:
  - i_COUNT = 0, i_WORD = 0x8000_0000_0000_0001 → o_WORD unchanged.
  - i_COUNT = 63, i_WORD = 0x8000_0000_0000_0000 → o_WORD = 1.
  - i_COUNT = 64 → o_WORD = 0, o_ZERO = 1, o_ERR = 0.
- Out-of-range:
  - Stimulus: i_COUNT = 100, i_WORD = 0xFFFF_FFFF_FFFF_FFFF.
  - Response: o_WORD = 0, o_ZERO = 1, o_ERR = 1; latency unchanged at 7.
- Backpressure:
  - Stimulus: hold i_READY = 0 for 5 cycles after o_VALID rises.
  - Response: o_VALID and o_WORD stable, o_READY = 0 throughout. Raise i_READY → o_READY = 1 next cycle; the next input is accepted on the cycle after.
- Reset mid-SHIFT:
  - Stimulus: assert i_RST at step k = 3.
  - Response: next cycle state IDLE, o_READY = 1, o_VALID = 0, o_WORD = 0; no stale result ever appears.
- Back-to-back:
  - Stimulus: i_VALID held high with counts 1, 2, 3 on word 0x8000_0000_0000_0000.
  - Response: results 0x4000…, 0x2000…, 0x1000… in order, spaced 9 cycles apart.
